// File: rtl/regfile_host_arbiter.sv
// Arbitrates the shared register file between the pipeline and a host/debug port.
// Pipeline traffic passes straight through. A single host read or write is slotted
// into a cycle where the relevant port is idle. After MAX_WAIT cycles without a free
// slot, pipe_hold is raised to force one.
module regfile_host_arbiter #(
  parameter int unsigned MAX_WAIT = 8  // 1..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  pipe_read_address_1,
  input  logic [5:0]  pipe_read_address_2,
  input  logic        pipe_read_valid,
  input  logic [5:0]  pipe_write_address,
  input  logic [31:0] pipe_write_value,
  input  logic        pipe_write_enable,
  output logic        pipe_hold,
  output logic [5:0]  rf_read_address_1,
  output logic [5:0]  rf_read_address_2,
  input  logic [31:0] rf_read_value_2,
  output logic [5:0]  rf_write_address,
  output logic [31:0] rf_write_value,
  output logic        rf_write_enable,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StAck} state_e;

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        req_we_q, req_we_d;
  logic [5:0]  req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] host_rdata_q, host_rdata_d;

  logic slot_state;
  logic read_free;
  logic write_free;
  logic grant_rd;
  logic grant_wr;

  // Grant decode: a host access only happens while a request is pending and its port is idle.
  // In HOLD the decode stage is frozen, so the read port is free regardless of pipe_read_valid.
  always_comb begin
    slot_state = (state_q == StWait) || (state_q == StHold);
    read_free  = !pipe_read_valid || (state_q == StHold);
    write_free = !pipe_write_enable;
    grant_rd   = slot_state && !req_we_q && read_free;
    grant_wr   = slot_state && req_we_q && write_free;
  end

  // Register file port muxing; pipeline signals pass through unless the host owns the slot.
  always_comb begin
    rf_read_address_1 = pipe_read_address_1;
    rf_read_address_2 = pipe_read_address_2;
    rf_write_address  = pipe_write_address;
    rf_write_value    = pipe_write_value;
    rf_write_enable   = pipe_write_enable;
    if (grant_rd) begin
      rf_read_address_2 = req_addr_q;
    end
    if (grant_wr) begin
      rf_write_address = req_addr_q;
      rf_write_value   = req_wdata_q;
      rf_write_enable  = 1'b1;
    end
  end

  // Next-state logic for the request FSM, wait counter, latched request and read result.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    host_rdata_d = host_rdata_q;

    if (grant_rd) begin
      host_rdata_d = rf_read_value_2;
    end

    unique case (state_q)
      StIdle: begin
        if (host_req) begin
          req_we_d    = host_we;
          req_addr_d  = host_addr;
          req_wdata_d = host_wdata;
          wait_cnt_d  = 8'd0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (grant_rd || grant_wr) begin
          state_d = StAck;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StHold;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (grant_rd || grant_wr) begin
          state_d = StAck;
        end
      end
      StAck: begin
        // host_req is deliberately ignored here; a still-high request restarts from IDLE.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= 8'd0;
      req_we_q     <= 1'b0;
      req_addr_q   <= 6'd0;
      req_wdata_q  <= 32'd0;
      host_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign host_ack   = (state_q == StAck);
  assign pipe_hold  = (state_q == StHold);
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_regfile_host_arbiter.sv
// Directed bench for regfile_host_arbiter with a behavioural 64x32 register file.
module tb_regfile_host_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  pipe_read_address_1;
  logic [5:0]  pipe_read_address_2;
  logic        pipe_read_valid;
  logic [5:0]  pipe_write_address;
  logic [31:0] pipe_write_value;
  logic        pipe_write_enable;
  logic        pipe_hold;
  logic [5:0]  rf_read_address_1;
  logic [5:0]  rf_read_address_2;
  logic [31:0] rf_read_value_2;
  logic [5:0]  rf_write_address;
  logic [31:0] rf_write_value;
  logic        rf_write_enable;
  logic        host_req;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] rf_mem [64];
  logic        preload_en = 1'b0;
  logic [5:0]  preload_addr = 6'd0;
  logic [31:0] preload_data = 32'd0;

  always #5 clock = ~clock;

  regfile_host_arbiter #(.MAX_WAIT(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .pipe_read_address_1 (pipe_read_address_1),
    .pipe_read_address_2 (pipe_read_address_2),
    .pipe_read_valid     (pipe_read_valid),
    .pipe_write_address  (pipe_write_address),
    .pipe_write_value    (pipe_write_value),
    .pipe_write_enable   (pipe_write_enable),
    .pipe_hold           (pipe_hold),
    .rf_read_address_1   (rf_read_address_1),
    .rf_read_address_2   (rf_read_address_2),
    .rf_read_value_2     (rf_read_value_2),
    .rf_write_address    (rf_write_address),
    .rf_write_value      (rf_write_value),
    .rf_write_enable     (rf_write_enable),
    .host_req            (host_req),
    .host_we             (host_we),
    .host_addr           (host_addr),
    .host_wdata          (host_wdata),
    .host_ack            (host_ack),
    .host_rdata          (host_rdata)
  );

  // Register file model: one synchronous write port, combinational read.
  always @(posedge clock) begin
    if (preload_en) rf_mem[preload_addr] <= preload_data;
    else if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_value;
  end
  assign rf_read_value_2 = rf_mem[rf_read_address_2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    preload_addr = a;
    preload_data = d;
    preload_en   = 1'b1;
    tick();
    preload_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pipe_read_address_1 = 6'd1;
    pipe_read_address_2 = 6'd7;
    pipe_read_valid     = 1'b0;
    pipe_write_address  = 6'd0;
    pipe_write_value    = 32'd0;
    pipe_write_enable   = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 6'd0; host_wdata = 32'd0;
    preload(6'd5, 32'hDEADBEEF);
    preload(6'd20, 32'hCAFE0020);
    tick();
    total++; if (host_ack !== 1'b0) $display("FAIL reset_ack: got %0b want 0", host_ack);
    else passed++;
    total++; if (pipe_hold !== 1'b0) $display("FAIL reset_hold: got %0b want 0", pipe_hold);
    else passed++;
    total++; if (host_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", host_rdata);
    else passed++;
    total++; if (rf_read_address_1 !== 6'd1)
      $display("FAIL reset_ra1: got %0d want 1", rf_read_address_1);
    else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_idle_read();
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5;
    tick();  // WAIT: slot free, grant now
    host_addr = 6'd9;  // must not matter after acceptance
    #1;
    total++; if (rf_read_address_2 !== 6'd5)
      $display("FAIL idle_read_addr: got %0d want 5", rf_read_address_2);
    else passed++;
    total++; if (host_ack !== 1'b0) $display("FAIL idle_read_early_ack: got %0b want 0", host_ack);
    else passed++;
    tick();  // ACK
    total++; if (host_ack !== 1'b1) $display("FAIL idle_read_ack: got %0b want 1", host_ack);
    else passed++;
    total++; if (host_rdata !== 32'hDEADBEEF)
      $display("FAIL idle_read_data: got %h want deadbeef", host_rdata);
    else passed++;
    total++; if (pipe_hold !== 1'b0) $display("FAIL idle_read_hold: got %0b want 0", pipe_hold);
    else passed++;
    host_req = 1'b0;
    tick();
    total++; if (host_ack !== 1'b0) $display("FAIL idle_read_ack_len: got %0b want 0", host_ack);
    else passed++;
  endtask

  task automatic test_write_collision();
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'd9; host_wdata = 32'h12345678;
    pipe_write_enable = 1'b1; pipe_write_address = 6'd10; pipe_write_value = 32'h100;
    tick();  // WAIT
    for (int i = 1; i < 3; i++) begin
      pipe_write_address = 6'(10 + i);
      pipe_write_value   = 32'h100 + 32'(i);
      #1;
      total++; if (rf_write_address !== 6'(10 + i) || rf_write_value !== 32'h100 + 32'(i))
        $display("FAIL wcol_pass%0d: got %0d/%h want %0d/%h", i, rf_write_address,
                 rf_write_value, 10 + i, 32'h100 + 32'(i));
      else passed++;
      tick();
    end
    pipe_write_enable = 1'b0;
    #1;
    total++; if (rf_write_enable !== 1'b1 || rf_write_address !== 6'd9 ||
                 rf_write_value !== 32'h12345678)
      $display("FAIL wcol_grant: got %0b/%0d/%h want 1/9/12345678", rf_write_enable,
               rf_write_address, rf_write_value);
    else passed++;
    tick();
    total++; if (host_ack !== 1'b1) $display("FAIL wcol_ack: got %0b want 1", host_ack);
    else passed++;
    host_req = 1'b0;
    tick();
    total++; if (rf_mem[9] !== 32'h12345678 || rf_mem[10] !== 32'h100 ||
                 rf_mem[11] !== 32'h101 || rf_mem[12] !== 32'h102)
      $display("FAIL wcol_mem: got %h %h %h %h want 12345678 100 101 102", rf_mem[9],
               rf_mem[10], rf_mem[11], rf_mem[12]);
    else passed++;
  endtask

  task automatic test_read_starvation();
    pipe_read_valid = 1'b1; pipe_read_address_2 = 6'd7;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd20;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (pipe_hold !== 1'b0 || rf_read_address_2 !== 6'd7)
        $display("FAIL rstarve_wait%0d: got hold=%0b addr=%0d want 0/7", i, pipe_hold,
                 rf_read_address_2);
      else passed++;
      tick();
    end
    total++; if (pipe_hold !== 1'b1 || rf_read_address_2 !== 6'd20)
      $display("FAIL rstarve_hold: got hold=%0b addr=%0d want 1/20", pipe_hold,
               rf_read_address_2);
    else passed++;
    tick();
    total++; if (host_ack !== 1'b1 || pipe_hold !== 1'b0 || host_rdata !== 32'hCAFE0020)
      $display("FAIL rstarve_ack: got ack=%0b hold=%0b data=%h want 1/0/cafe0020", host_ack,
               pipe_hold, host_rdata);
    else passed++;
    host_req = 1'b0; pipe_read_valid = 1'b0;
    tick();
  endtask

  task automatic test_write_starvation();
    pipe_write_enable = 1'b1; pipe_write_address = 6'd30; pipe_write_value = 32'h0BAD0030;
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'd31; host_wdata = 32'h5555AAAA;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (pipe_hold !== 1'b0 || rf_write_address !== 6'd30)
        $display("FAIL wstarve_wait%0d: got hold=%0b addr=%0d want 0/30", i, pipe_hold,
                 rf_write_address);
      else passed++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (pipe_hold !== 1'b1 || rf_write_address !== 6'd30 ||
                   rf_write_value !== 32'h0BAD0030)
        $display("FAIL wstarve_hold%0d: got hold=%0b addr=%0d want 1/30", i, pipe_hold,
                 rf_write_address);
      else passed++;
      tick();
    end
    pipe_write_enable = 1'b0;
    #1;
    total++; if (pipe_hold !== 1'b1 || rf_write_enable !== 1'b1 || rf_write_address !== 6'd31 ||
                 rf_write_value !== 32'h5555AAAA)
      $display("FAIL wstarve_grant: got hold=%0b we=%0b addr=%0d val=%h want 1/1/31/5555aaaa",
               pipe_hold, rf_write_enable, rf_write_address, rf_write_value);
    else passed++;
    tick();
    total++; if (host_ack !== 1'b1 || pipe_hold !== 1'b0)
      $display("FAIL wstarve_ack: got ack=%0b hold=%0b want 1/0", host_ack, pipe_hold);
    else passed++;
    host_req = 1'b0;
    tick();
    total++; if (rf_mem[31] !== 32'h5555AAAA || rf_mem[30] !== 32'h0BAD0030)
      $display("FAIL wstarve_mem: got %h %h want 5555aaaa 0bad0030", rf_mem[31], rf_mem[30]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic ack_seen;
    ack_seen = 1'b0;
    pipe_read_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5;
    tick();  // WAIT, blocked by pipeline reads
    #2;
    reset = 1'b0;
    #1;
    total++; if (host_ack !== 1'b0 || pipe_hold !== 1'b0 || host_rdata !== 32'd0)
      $display("FAIL rstmid_state: got ack=%0b hold=%0b data=%h want 0/0/0", host_ack,
               pipe_hold, host_rdata);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (host_ack === 1'b1) ack_seen = 1'b1;
    end
    host_req = 1'b0; pipe_read_valid = 1'b0;
    reset = 1'b1;
    tick();
    if (host_ack === 1'b1) ack_seen = 1'b1;
    total++; if (ack_seen !== 1'b0) $display("FAIL rstmid_noack: got 1 want 0");
    else passed++;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5;
    tick();
    tick();
    total++; if (host_ack !== 1'b1 || host_rdata !== 32'hDEADBEEF)
      $display("FAIL rstmid_after: got ack=%0b data=%h want 1/deadbeef", host_ack, host_rdata);
    else passed++;
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'd3; host_wdata = 32'hA;
    tick();  // WAIT, write granted
    tick();  // ACK
    total++; if (host_ack !== 1'b1) $display("FAIL b2b_ack1: got %0b want 1", host_ack);
    else passed++;
    host_we = 1'b0;  // request stays high, now a read
    tick();  // IDLE
    total++; if (host_ack !== 1'b0) $display("FAIL b2b_gap: got %0b want 0", host_ack);
    else passed++;
    tick();  // WAIT, read granted
    total++; if (rf_read_address_2 !== 6'd3)
      $display("FAIL b2b_raddr: got %0d want 3", rf_read_address_2);
    else passed++;
    tick();  // ACK
    total++; if (host_ack !== 1'b1 || host_rdata !== 32'hA)
      $display("FAIL b2b_ack2: got ack=%0b data=%h want 1/0000000a", host_ack, host_rdata);
    else passed++;
    host_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_write_collision();
    test_read_starvation();
    test_write_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
